// File: rtl/instr_issue_ctrl_if.sv
// Bundle between the PDP-8 decoder/execution unit and the issue controller.
// master = the surrounding system, slave = instr_issue_ctrl.
interface instr_issue_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic [5:0]              in_mem_code;
  logic [ADDR_WIDTH-1:0]   in_addr;
  logic [21:0]             in_op7_code;
  logic [ADDR_WIDTH-1:0]   in_pc;
  logic                    stall;
  logic [ADDR_WIDTH-1:0]   PC_value;
  logic [6+ADDR_WIDTH-1:0] pdp_mem_opcode;
  logic [21:0]             pdp_op7_opcode;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic                    flush;
  logic [15:0]             issue_cnt;
  logic [7:0]              err_cnt;

  modport master (
    output in_valid, in_mem_code, in_addr, in_op7_code, in_pc, stall, PC_value,
    input  in_ready, pdp_mem_opcode, pdp_op7_opcode, base_addr, flush, issue_cnt, err_cnt
  );

  modport slave (
    input  in_valid, in_mem_code, in_addr, in_op7_code, in_pc, stall, PC_value,
    output in_ready, pdp_mem_opcode, pdp_op7_opcode, base_addr, flush, issue_cnt, err_cnt
  );
endinterface

// File: rtl/instr_issue_ctrl.sv
// Issue queue between a PDP-8 decoder and its execution unit: queues decoded
// instructions, issues one at a time and flushes when the PC is redirected.
module instr_issue_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200
) (
  input logic               clk,
  input logic               reset_n,
  instr_issue_ctrl_if.slave bus
);
  localparam int unsigned    PW      = $clog2(DEPTH);
  localparam int unsigned    EW      = 6 + ADDR_WIDTH + 22 + ADDR_WIDTH;
  localparam logic [PW:0]    DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;
  logic                  wait_first_q, wait_first_d;
  logic [ADDR_WIDTH-1:0] exp_pc_q, exp_pc_d;
  logic [15:0]           issue_cnt_q, issue_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  accept, well_formed, enq, pop;
  logic [EW-1:0]         entry, head;
  logic [5:0]            head_mem;
  logic [ADDR_WIDTH-1:0] head_addr, head_pc, issue_addr;
  logic [21:0]           head_op7;

  assign well_formed = ($countones({bus.in_mem_code, bus.in_op7_code}) == 1);
  assign accept      = bus.in_valid && bus.in_ready;
  assign enq         = accept && well_formed;
  assign entry       = {bus.in_mem_code, bus.in_addr, bus.in_op7_code, bus.in_pc};

  assign head      = mem_q[rd_ptr_q];
  assign head_mem  = head[EW-1 -: 6];
  assign head_addr = head[EW-7 -: ADDR_WIDTH];
  assign head_op7  = head[ADDR_WIDTH+21 -: 22];
  assign head_pc   = head[ADDR_WIDTH-1:0];

  // op7 micro-ops carry no operand, so the address field stays zero for them
  assign issue_addr = (head_mem != 6'd0) ? head_addr : {ADDR_WIDTH{1'b0}};

  assign bus.in_ready       = (count_q < DEPTH_C) && (state_q != FLUSH);
  assign bus.pdp_mem_opcode = (state_q == ISSUE) ? {head_mem, issue_addr} : {(6+ADDR_WIDTH){1'b0}};
  assign bus.pdp_op7_opcode = (state_q == ISSUE) ? head_op7 : 22'd0;
  assign bus.flush          = (state_q == FLUSH);
  assign bus.base_addr      = START_ADDR;
  assign bus.issue_cnt      = issue_cnt_q;
  assign bus.err_cnt        = err_cnt_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wait_first_d = 1'b0;
    exp_pc_d     = exp_pc_q;
    issue_cnt_d  = issue_cnt_q;
    err_cnt_d    = err_cnt_q;
    pop          = 1'b0;

    if (accept && !well_formed && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if ((count_q != '0) && !bus.stall)
          state_d = ISSUE;
      end
      ISSUE: begin
        pop          = 1'b1;
        exp_pc_d     = head_pc + 1'b1;
        issue_cnt_d  = issue_cnt_q + 16'd1;
        wait_first_d = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        // the execution unit needs a cycle before its stall reflects the new op
        if (!wait_first_q && !bus.stall)
          state_d = (bus.PC_value == exp_pc_q) ? IDLE : FLUSH;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (state_q == FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wait_first_q <= 1'b0;
      exp_pc_q     <= '0;
      issue_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wait_first_q <= wait_first_d;
      exp_pc_q     <= exp_pc_d;
      issue_cnt_q  <= issue_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // queue storage needs no reset: occupancy decides what is valid
  always_ff @(posedge clk) begin
    if (enq)
      mem_q[wr_ptr_q] <= entry;
  end
endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Self-checking bench for instr_issue_ctrl: directed scenarios plus a
// randomized run against a queue-level reference model of the issue rules.
module tb_instr_issue_ctrl;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4;
  localparam logic [AW-1:0] START = 12'o200;

  localparam logic [5:0] M_JMP = 6'b000001;
  localparam logic [5:0] M_DCA = 6'b000100;
  localparam logic [5:0] M_TAD = 6'b010000;
  localparam logic [21:0] OP_NOP = 22'h200000;

  typedef struct {
    logic [5:0]    mem;
    logic [AW-1:0] addr;
    logic [21:0]   op7;
    logic [AW-1:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  instr_issue_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  instr_issue_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .START_ADDR(START)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_mem_code = '0;
    bus.in_addr     = '0;
    bus.in_op7_code = '0;
    bus.in_pc       = '0;
  endtask

  task automatic offer(input logic [5:0] mem, input logic [21:0] op7,
                       input logic [AW-1:0] addr, input logic [AW-1:0] pc);
    bus.in_valid    = 1'b1;
    bus.in_mem_code = mem;
    bus.in_op7_code = op7;
    bus.in_addr     = addr;
    bus.in_pc       = pc;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.stall    = 1'b0;
    bus.PC_value = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic bit issuing();
    return (bus.pdp_mem_opcode != '0) || (bus.pdp_op7_opcode != '0);
  endfunction

  task automatic test_reset();
    idle_inputs();
    bus.stall = 1'b0;
    bus.PC_value = '0;
    #1 reset_n = 1'b0;
    #3;
    n_cmp++; if (bus.base_addr !== START) begin n_fail++; $display("FAIL rst_base_addr: got %0o expected %0o", bus.base_addr, START); end
    n_cmp++; if (bus.pdp_mem_opcode !== '0) begin n_fail++; $display("FAIL rst_mem_op: got %0h expected 0", bus.pdp_mem_opcode); end
    n_cmp++; if (bus.pdp_op7_opcode !== '0) begin n_fail++; $display("FAIL rst_op7_op: got %0h expected 0", bus.pdp_op7_opcode); end
    n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %0b expected 0", bus.flush); end
    n_cmp++; if (bus.issue_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_issue_cnt: got %0d expected 0", bus.issue_cnt); end
    n_cmp++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d expected 0", bus.err_cnt); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b expected 1", bus.in_ready); end
  endtask

  task automatic test_tad_issue();
    int seen;
    logic [17:0] cap_m;
    logic [21:0] cap_7;
    int fl;
    seen = 0; fl = 0; cap_m = '0; cap_7 = '0;
    do_reset();
    bus.PC_value = 12'o0201;
    offer(M_TAD, 22'd0, 12'o0005, 12'o0200);
    @(negedge clk);
    idle_inputs();
    n_cmp++; if (issuing()) begin n_fail++; $display("FAIL tad_same_cycle: got %0h expected 0", bus.pdp_mem_opcode); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.flush) fl++;
      if (issuing()) begin seen++; cap_m = bus.pdp_mem_opcode; cap_7 = bus.pdp_op7_opcode; end
    end
    n_cmp++; if (seen != 1) begin n_fail++; $display("FAIL tad_issue_cycles: got %0d expected 1", seen); end
    n_cmp++; if (cap_m !== {M_TAD, 12'o0005}) begin n_fail++; $display("FAIL tad_mem_opcode: got %0h expected %0h", cap_m, {M_TAD, 12'o0005}); end
    n_cmp++; if (cap_7 !== 22'd0) begin n_fail++; $display("FAIL tad_op7_opcode: got %0h expected 0", cap_7); end
    n_cmp++; if (bus.issue_cnt !== 16'd1) begin n_fail++; $display("FAIL tad_issue_cnt: got %0d expected 1", bus.issue_cnt); end
    n_cmp++; if (fl != 0) begin n_fail++; $display("FAIL tad_no_flush: got %0d expected 0", fl); end
  endtask

  task automatic test_backpressure();
    bit acc, got_first;
    logic [17:0] first;
    acc = 0; got_first = 0; first = '0;
    do_reset();
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus.in_ready !== (i < 4)) begin n_fail++; $display("FAIL bp_ready_%0d: got %0b expected %0b", i, bus.in_ready, (i < 4)); end
      offer(M_DCA, 22'd0, 12'(i + 1), 12'(i));
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.in_ready !== 1'b0 || issuing()) begin n_fail++; $display("FAIL bp_hold: got ready=%0b issue=%0b expected 0/0", bus.in_ready, issuing()); end
      @(negedge clk);
    end
    bus.stall = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      if (!got_first && issuing()) begin first = bus.pdp_mem_opcode; got_first = 1; end
      if (bus.in_ready) acc = got_first;
    end
    if (acc) @(negedge clk);
    idle_inputs();
    n_cmp++; if (!acc) begin n_fail++; $display("FAIL bp_fifth_accept: got 0 expected 1"); end
    n_cmp++; if (first !== {M_DCA, 12'd1}) begin n_fail++; $display("FAIL bp_first_issue: got %0h expected %0h", first, {M_DCA, 12'd1}); end
  endtask

  task automatic test_flush();
    int fl, iss;
    logic [17:0] cap;
    fl = 0; iss = 0; cap = '0;
    do_reset();
    bus.stall = 1'b1;
    bus.PC_value = 12'o0300;
    offer(M_JMP, 22'd0, 12'o0300, 12'o0201);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      offer(M_DCA, 22'd0, 12'(12'o0400 + i), 12'(12'o0202 + i));
      @(negedge clk);
    end
    idle_inputs();
    bus.stall = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.flush) fl++;
      if (issuing()) begin iss++; cap = bus.pdp_mem_opcode; end
    end
    n_cmp++; if (fl != 1) begin n_fail++; $display("FAIL flush_pulses: got %0d expected 1", fl); end
    n_cmp++; if (iss != 1) begin n_fail++; $display("FAIL flush_issues: got %0d expected 1", iss); end
    n_cmp++; if (cap !== {M_JMP, 12'o0300}) begin n_fail++; $display("FAIL flush_jmp_opcode: got %0h expected %0h", cap, {M_JMP, 12'o0300}); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b expected 1", bus.in_ready); end
    n_cmp++; if (bus.issue_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_issue_cnt: got %0d expected 1", bus.issue_cnt); end
  endtask

  task automatic test_nop_no_flush();
    int fl, iss, iss2, hold;
    logic [21:0] cap7;
    logic [17:0] capm;
    fl = 0; iss = 0; iss2 = 0; hold = 0; cap7 = '0; capm = '1;
    do_reset();
    bus.PC_value = 12'o0203;
    offer(6'd0, OP_NOP, 12'd0, 12'o0202);
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.flush) fl++;
      if (issuing()) begin iss++; cap7 = bus.pdp_op7_opcode; capm = bus.pdp_mem_opcode; hold = 4; end
      bus.stall = (hold > 0);
      if (hold > 0) hold--;
    end
    n_cmp++; if (iss != 1) begin n_fail++; $display("FAIL nop_issues: got %0d expected 1", iss); end
    n_cmp++; if (cap7 !== OP_NOP || capm !== '0) begin n_fail++; $display("FAIL nop_opcode: got %0h/%0h expected %0h/0", cap7, capm, OP_NOP); end
    n_cmp++; if (fl != 0) begin n_fail++; $display("FAIL nop_flush: got %0d expected 0", fl); end
    bus.PC_value = 12'o0204;
    offer(6'd0, OP_NOP, 12'd0, 12'o0203);
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (issuing()) iss2++;
    end
    n_cmp++; if (iss2 != 1) begin n_fail++; $display("FAIL nop_back_to_idle: got %0d expected 1", iss2); end
  endtask

  task automatic test_malformed();
    int iss;
    logic [7:0] exp8;
    iss = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 1 || i == 10 || i == 255 || i == 256 || i == 599) begin
        exp8 = (i > 255) ? 8'd255 : 8'(i);
        n_cmp++;
        if (bus.err_cnt !== exp8) begin n_fail++; $display("FAIL err_cnt_at_%0d: got %0d expected %0d", i, bus.err_cnt, exp8); end
      end
      if (issuing()) iss++;
      offer((i % 2 == 0) ? 6'b000011 : 6'd0, 22'd0, 12'(i), 12'(i));
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_saturate: got %0d expected 255", bus.err_cnt); end
    n_cmp++; if (iss != 0 || bus.issue_cnt !== 16'd0) begin n_fail++; $display("FAIL malformed_issued: got %0d/%0d expected 0/0", iss, bus.issue_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    int iss, fl;
    got = 0; iss = 0; fl = 0;
    do_reset();
    bus.stall = 1'b1;
    offer(6'd0, 22'd0, 12'd0, 12'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      offer(M_DCA, 22'd0, 12'(i), 12'(i));
      @(negedge clk);
    end
    idle_inputs();
    bus.stall = 1'b0;
    bus.PC_value = 12'o7777;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (issuing()) begin got = 1; bus.stall = 1'b1; end
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (!got || bus.issue_cnt !== 16'd1 || bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL rmw_setup: got issued=%0b cnt=%0d err=%0d expected 1/1/1", got, bus.issue_cnt, bus.err_cnt); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.pdp_mem_opcode !== '0 || bus.pdp_op7_opcode !== '0) begin n_fail++; $display("FAIL rmw_opcodes: got %0h/%0h expected 0/0", bus.pdp_mem_opcode, bus.pdp_op7_opcode); end
    n_cmp++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL rmw_flush: got %0b expected 0", bus.flush); end
    n_cmp++; if (bus.issue_cnt !== 16'd0 || bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL rmw_counters: got %0d/%0d expected 0/0", bus.issue_cnt, bus.err_cnt); end
    n_cmp++; if (bus.base_addr !== START) begin n_fail++; $display("FAIL rmw_base_addr: got %0o expected %0o", bus.base_addr, START); end
    @(negedge clk);
    reset_n = 1'b1;
    bus.stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (issuing()) iss++;
      if (bus.flush) fl++;
    end
    n_cmp++; if (iss != 0 || fl != 0) begin n_fail++; $display("FAIL rmw_after: got issues=%0d flushes=%0d expected 0/0", iss, fl); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_ready: got %0b expected 1", bus.in_ready); end
  endtask

  // Reference: ordered queue of accepted well-formed ops; one op outstanding
  // at a time; outcome decided at the first stall-free cycle >= issue+2.
  task automatic test_random();
    ent_t mq[$];
    ent_t e;
    int issues, errs, t_issue, t_res;
    bit pending, resolved, exp_fl, fl_now, exp_ready, is_iss, exp_iss, idle_now, stl;
    logic [AW-1:0] target, exp_pc_m;
    logic [17:0] exp_m;
    logic [27:0] oh;
    int r, b1, b2;
    issues = 0; errs = 0; t_issue = 0; t_res = 0;
    pending = 0; resolved = 0; exp_fl = 0; exp_iss = 0;
    target = '0;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      fl_now    = resolved && exp_fl && (cyc == t_res + 1);
      exp_ready = !fl_now && (mq.size() < DEPTH);
      is_iss    = issuing();
      n_cmp++; if (bus.in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", cyc, bus.in_ready, exp_ready); end
      n_cmp++; if (bus.flush !== fl_now) begin n_fail++; $display("FAIL rnd_flush c%0d: got %0b expected %0b", cyc, bus.flush, fl_now); end
      n_cmp++; if (bus.issue_cnt !== 16'(issues)) begin n_fail++; $display("FAIL rnd_issue_cnt c%0d: got %0d expected %0d", cyc, bus.issue_cnt, issues); end
      n_cmp++; if (bus.err_cnt !== ((errs > 255) ? 8'd255 : 8'(errs))) begin n_fail++; $display("FAIL rnd_err_cnt c%0d: got %0d expected %0d", cyc, bus.err_cnt, errs); end
      n_cmp++; if (is_iss !== exp_iss) begin n_fail++; $display("FAIL rnd_issue_time c%0d: got %0b expected %0b", cyc, is_iss, exp_iss); end
      if (fl_now) mq.delete();
      if (resolved && (cyc == t_res + 1)) begin pending = 0; resolved = 0; end
      if (is_iss && mq.size() > 0) begin
        e = mq.pop_front();
        exp_m = {e.mem, (e.mem != '0) ? e.addr : 12'd0};
        n_cmp++;
        if (bus.pdp_mem_opcode !== exp_m || bus.pdp_op7_opcode !== e.op7) begin
          n_fail++; $display("FAIL rnd_opcode c%0d: got %0h/%0h expected %0h/%0h", cyc, bus.pdp_mem_opcode, bus.pdp_op7_opcode, exp_m, e.op7);
        end
        issues++;
        pending  = 1; resolved = 0; t_issue = cyc;
        exp_pc_m = e.pc + 12'd1;
        target   = ($urandom_range(0, 1) == 0) ? exp_pc_m : exp_pc_m + 12'($urandom_range(1, 4095));
        exp_fl   = (target != exp_pc_m);
      end
      idle_now = !pending && !fl_now && !is_iss;
      stl = ((cyc / 200) % 2 == 1) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
      bus.stall = stl;
      if (pending && !resolved && (cyc >= t_issue + 2) && !stl) begin resolved = 1; t_res = cyc; end
      bus.PC_value = pending ? target : 12'($urandom);
      exp_iss = idle_now && (mq.size() > 0) && !stl;
      if ($urandom_range(0, 9) < 6) begin
        r = $urandom_range(0, 9);
        b1 = $urandom_range(0, 27);
        b2 = (b1 + $urandom_range(1, 27)) % 28;
        oh = (r < 8) ? (28'd1 << b1) : (r == 8) ? 28'd0 : ((28'd1 << b1) | (28'd1 << b2));
        offer(oh[27:22], oh[21:0], 12'($urandom), 12'($urandom));
        if (exp_ready) begin
          if (r < 8) begin
            e.mem = oh[27:22]; e.op7 = oh[21:0]; e.addr = bus.in_addr; e.pc = bus.in_pc;
            mq.push_back(e);
          end else begin
            errs++;
          end
        end
      end else begin
        idle_inputs();
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.stall    = 1'b0;
    bus.PC_value = '0;
    test_reset();
    test_tad_issue();
    test_backpressure();
    test_flush();
    test_nop_no_flush();
    test_malformed();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
